array_sort_check_datapath: RTL
==============================

ARRAY_SORT_CHECK_DATAPATH -- requirements
Module: array_sort_check_datapath

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-002 clock  input  1  sole clock; all registers update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all registers.
REQ-004 load_input  input  1  captures start and length; restarts the scan.
REQ-005 load_index  input  1  index register write enable.
REQ-006 select_index  input  1  0: index restarts at 0; 1: index advances by 1.
REQ-007 start  input  8  word address of array element 0.
REQ-008 length  input  8  element count, 0..255.
REQ-009 mem_addr  output  8  read address into the external word memory.
REQ-010 mem_rdata  input  32  word at mem_addr; combinational read, same cycle.
REQ-011 inversion_found  output  1  an out-of-order adjacent pair has been seen in this scan.
REQ-012 end_of_array  output  1  the current index is the last element, or the array is empty.
REQ-013 zero_length_array  output  1  the captured length is 0.

Function
REQ-014 Registers SHALL be: start_r[7:0], len_r[7:0], idx[7:0], prev_data[31:0], prev_valid, inv_sticky.
REQ-015 mem_addr SHALL equal start_r + idx, truncated to 8 bits (wraps 255 -> 0).
REQ-016 load_input=1 SHALL load start_r<=start, len_r<=length, idx<=0, prev_valid<=0, inv_sticky<=0; load_input SHALL take priority over load_index in the same cycle.
REQ-017 load_index=1 with select_index=0 (and load_input=0) SHALL load idx<=0, prev_valid<=0, inv_sticky<=0.
REQ-018 load_index=1 with select_index=1 SHALL load prev_data<=mem_rdata, prev_valid<=1, inv_sticky<=inversion_found, and idx<=idx+1.
REQ-019 In the REQ-018 case, when end_of_array=1, idx SHALL hold its value; prev_data, prev_valid and inv_sticky SHALL still update.
REQ-020 When load_index=0 and load_input=0, all registers SHALL hold.
REQ-021 Combinational compare: cmp_inv = prev_valid & (prev_data > mem_rdata), signed 32-bit by default; equal values SHALL NOT be an inversion.
REQ-022 inversion_found SHALL equal inv_sticky | cmp_inv.
REQ-023 zero_length_array SHALL equal (len_r == 0).
REQ-024 end_of_array SHALL equal (len_r == 0) | ({1'b0,idx} + 1 >= {1'b0,len_r}), evaluated at 9-bit width; idx 254 with len_r 255 SHALL give 1.
REQ-025 Latency: each advance SHALL compare one adjacent pair per cycle; an N-element array SHALL need N-1 advances after the index restart.
REQ-026 All outputs SHALL be combinational functions of the registers and mem_rdata only; there SHALL be no combinational path from the control inputs to any output.

Reset
REQ-027 reset=1 SHALL immediately clear every register to 0, regardless of clock.
REQ-028 Outputs during reset SHALL be: mem_addr=0, zero_length_array=1, end_of_array=1, inversion_found=0.
REQ-029 Reset asserted mid-scan SHALL discard all scan state; the next scan SHALL require load_input.

Configuration
REQ-030 With ARRAY_SORT_UNSIGNED_EN defined, the REQ-021 compare SHALL be unsigned.
REQ-031 Without ARRAY_SORT_UNSIGNED_EN, the REQ-021 compare SHALL be signed two's complement; no other behaviour SHALL differ.

Verification
REQ-032 Array at start=0x10, length=4, values {1,2,2,7}; load_input, index restart, then 3 advances -> after the 3rd advance end_of_array=1 and inversion_found=0; mem_addr sequence 0x10, 0x11, 0x12, 0x13.
REQ-033 Values {5,3,9} at start=0x20, length=3 -> inversion_found=1 at idx=1 and stays 1 through idx=2 with end_of_array=1.
REQ-034 length=0 -> zero_length_array=1 and end_of_array=1 the cycle after load_input; an advance leaves idx=0.
REQ-035 start=0xFE, length=3, values {0,1,2} -> mem_addr sequence 0xFE, 0xFF, 0x00; inversion_found=0.
REQ-036 Values {0xFFFFFFFF, 0x00000001}: default build -> inversion_found=0; build with ARRAY_SORT_UNSIGNED_EN -> inversion_found=1.
REQ-037 Assert reset asynchronously mid-scan with inv_sticky=1 -> same cycle: mem_addr=0, inversion_found=0; a new load_input then scans {1,2} correctly with inversion_found=0.

Source files
------------

// File: rtl/array_sort_check_datapath.sv
// ----------------------------------------------------------------------------
// ArraySortCheckDatapath
//
// Purpose:
//   Walks an array held in an external word memory one element per advance
//   and reports whether any adjacent pair is out of order (prev > next).
//   The controlling FSM lives outside this block. It drives load_input to
//   capture a new array descriptor. It drives load_index to restart or
//   advance the scan index.
//
// Configuration:
//   ARRAY_SORT_UNSIGNED_EN - when defined, elements are compared as unsigned
//                            32-bit values. The default build compares them
//                            as signed two's complement.
//
// Ports:
//   clock             - sole clock, rising edge
//   reset             - asynchronous, active-high, clears every register
//   load_input        - capture start/length and restart the scan
//   load_index        - index register write enable
//   select_index      - 0: restart index at 0, 1: advance index by 1
//   start[7:0]        - word address of element 0
//   length[7:0]       - element count, 0..255
//   mem_addr[7:0]     - read address into the external memory
//   mem_rdata[31:0]   - word at mem_addr (combinational read)
//   inversion_found   - an out-of-order adjacent pair has been seen
//   end_of_array      - current index is the last element, or array is empty
//   zero_length_array - captured length is 0
// ----------------------------------------------------------------------------
module array_sort_check_datapath (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_input,
    input  logic        load_index,
    input  logic        select_index,
    input  logic [7:0]  start,
    input  logic [7:0]  length,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        inversion_found,
    output logic        end_of_array,
    output logic        zero_length_array
);

    logic [7:0]  startR;
    logic [7:0]  lenR;
    logic [7:0]  idx;
    logic [31:0] prevData;
    logic        prevValid;
    logic        invSticky;
    logic        prevGreater;
    logic        cmpInv;

    // Element ordering test between the previously read word and the word
    // currently on the memory bus. Equal values are never an inversion.
    always_comb begin
        prevGreater = 1'b0;
`ifdef ARRAY_SORT_UNSIGNED_EN
        prevGreater = (prevData > mem_rdata);
`else
        prevGreater = ($signed(prevData) > $signed(mem_rdata));
`endif
    end

    // A comparison only means something once a previous element is held.
    // The sticky flag remembers pairs that have already scrolled past.
    // The 9-bit end test keeps idx+1 from wrapping when idx is 255.
    always_comb begin
        cmpInv            = prevValid & prevGreater;
        inversion_found   = invSticky | cmpInv;
        zero_length_array = (lenR == 8'd0);
        end_of_array      = (lenR == 8'd0) |
                            (({1'b0, idx} + 9'd1) >= {1'b0, lenR});
        mem_addr          = startR + idx;
    end

    // Scan state registers. load_input wins over load_index. An advance on
    // the last element still folds the final pair into the sticky flag.
    // The index stays put so mem_addr never leaves the array.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            startR    <= 8'd0;
            lenR      <= 8'd0;
            idx       <= 8'd0;
            prevData  <= 32'd0;
            prevValid <= 1'b0;
            invSticky <= 1'b0;
        end else if (load_input) begin
            startR    <= start;
            lenR      <= length;
            idx       <= 8'd0;
            prevValid <= 1'b0;
            invSticky <= 1'b0;
        end else if (load_index) begin
            if (!select_index) begin
                idx       <= 8'd0;
                prevValid <= 1'b0;
                invSticky <= 1'b0;
            end else begin
                prevData  <= mem_rdata;
                prevValid <= 1'b1;
                invSticky <= inversion_found;
                if (!end_of_array) begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

endmodule
